// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, the core memory stage,
// the debug coprocessor IO requester and the data memory.
// slave  : the arbiter's view.
// master : the view of whatever drives the core/coprocessor/memory side.
interface dmem_arbiter_if #(
    parameter int N  = 64,
    parameter int AW = 15
);
    // core memory stage
    logic          core_re;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [N-1:0]  core_wdata;
    logic [2:0]    core_width;
    logic          core_stall;

    // debug coprocessor
    logic          cp_halt;
    logic          cp_req;
    logic          cp_we;
    logic [AW-1:0] cp_addr;
    logic [N-1:0]  cp_wdata;
    logic          cp_gnt;
    logic          cp_rvalid;
    logic [N-1:0]  cp_rdata;

    // data memory
    logic          mem_re;
    logic          mem_we;
    logic [AW-4:0] mem_wordAddr;
    logic [2:0]    mem_byteOffset;
    logic [2:0]    mem_width;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_rdata;

    modport slave (
        input  core_re, core_we, core_addr, core_wdata, core_width,
        output core_stall,
        input  cp_halt, cp_req, cp_we, cp_addr, cp_wdata,
        output cp_gnt, cp_rvalid, cp_rdata,
        output mem_re, mem_we, mem_wordAddr, mem_byteOffset, mem_width, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_re, core_we, core_addr, core_wdata, core_width,
        input  core_stall,
        output cp_halt, cp_req, cp_we, cp_addr, cp_wdata,
        input  cp_gnt, cp_rvalid, cp_rdata,
        input  mem_re, mem_we, mem_wordAddr, mem_byteOffset, mem_width, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core memory stage vs. debug coprocessor.
// The core has default priority; the coprocessor wins when the core is
// idle, when the core is halted, or when it has been denied STARVE_MAX
// consecutive cycles. The memory reads asynchronously, so every
// coprocessor access completes in its grant cycle; a read's data is
// captured on the grant edge and returned with a one-cycle cp_rvalid.
module dmem_arbiter #(
    parameter int N          = 64,
    parameter int AW         = 15,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,   // asynchronous, active low
    dmem_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CP_ACC  = 2'd1,
        CP_RESP = 2'd2
    } state_t;

    state_t        state, stateNext;
    logic [CW-1:0] starveCnt, starveCntNext;
    logic [N-1:0]  cpRdata;

    logic coreAct;
    logic forced;
    logic cpWin;
    logic cpGnt;
    logic coreStall;

    // Grant decision and next state. Grants are only issued from IDLE,
    // which is what limits back-to-back reads to one per two cycles.
    always_comb begin
        stateNext = state;
        cpGnt     = 1'b0;
        coreStall = 1'b0;
        coreAct   = bus.core_re | bus.core_we;
        forced    = (starveCnt == STARVE_LIM);
        cpWin     = bus.cp_req & (bus.cp_halt | ~coreAct | forced);
        case (state)
            IDLE: begin
                if (cpWin) begin
                    cpGnt     = 1'b1;
                    stateNext = bus.cp_we ? IDLE : CP_RESP;
                end
            end
            // With a single-cycle memory the forced access happens in the
            // IDLE grant cycle itself, which is the one cycle the core is
            // held off, so this state is not entered. It is kept as a park
            // state for a slower memory: the core is held one cycle and
            // the port then goes back to normal arbitration.
            CP_ACC: begin
                coreStall = coreAct;
                stateNext = IDLE;
            end
            // Response cycle: the core owns the port again.
            CP_RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        // Nothing is granted while reset is held.
        if (!reset) begin
            cpGnt     = 1'b0;
            coreStall = 1'b0;
        end
        // A forced grant stalls the core unless the debugger froze it.
        if (cpGnt && coreAct)
            coreStall = 1'b1;
        if (bus.cp_halt)
            coreStall = 1'b0;
    end

    // Starvation counter: counts denied request cycles, saturating.
    always_comb begin
        starveCntNext = starveCnt;
        if (!bus.cp_req || cpGnt)
            starveCntNext = '0;
        else if (!forced)
            starveCntNext = starveCnt + 1'b1;
    end

    // Port mux: the coprocessor owns the port only in its grant cycle.
    always_comb begin
        bus.mem_re         = bus.core_re;
        bus.mem_we         = bus.core_we;
        bus.mem_wordAddr   = bus.core_addr[AW-1:3];
        bus.mem_byteOffset = bus.core_addr[2:0];
        bus.mem_width      = bus.core_width;
        bus.mem_wdata      = bus.core_wdata;
        if (cpGnt) begin
            bus.mem_re         = ~bus.cp_we;
            bus.mem_we         = bus.cp_we;
            bus.mem_wordAddr   = bus.cp_addr[AW-1:3];
            bus.mem_byteOffset = bus.cp_addr[2:0];
            bus.mem_width      = 3'b111;
            bus.mem_wdata      = bus.cp_wdata;
        end
    end

    // Handshake outputs.
    always_comb begin
        bus.cp_gnt     = cpGnt;
        bus.cp_rvalid  = (state == CP_RESP);
        bus.core_stall = coreStall;
        bus.cp_rdata   = cpRdata;
    end

    // State register; reset drops any pending response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starveCnt <= '0;
        else
            starveCnt <= starveCntNext;
    end

    // Capture read data on the grant edge of a coprocessor read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cpRdata <= '0;
        else if (cpGnt && !bus.cp_we)
            cpRdata <= bus.mem_rdata;
    end
endmodule
